// File: rtl/axi_slice_dc_chan_reader.sv
// axi_slice_dc_chan_reader: read-side endpoint of one dual-clock AXI slice channel
//
// Ports:
//   clk_i, rst_ni    reader clock, asynchronous active-low reset
//   isolate_i        freeze: no valid presented, no slot consumed
//   isolated_o       isolate_i registered (isolation acknowledge)
//   data_async_i     writer's slot storage, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   writetoken_i     async per-slot write toggles from the writer
//   readpointer_o    registered per-slot read toggles back to the writer
//   data_o, valid_o  head-slot payload and valid; ready_i accepts it
//   fill_o           registered count of occupied slots after synchronisation
module axi_slice_dc_chan_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               isolate_i,
    output logic                               isolated_o,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
    input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
    output logic [BUFFER_WIDTH-1:0]            readpointer_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  fill_o
);
    localparam int IW = $clog2(BUFFER_WIDTH);
    localparam int FW = $clog2(BUFFER_WIDTH + 1);

    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] rp_q;
    logic [BUFFER_WIDTH-1:0] occupied;
    logic [IW-1:0]           rd_idx;
    logic [DATA_WIDTH-1:0]   slot [BUFFER_WIDTH];
    logic                    pop;

    for (genvar g = 0; g < BUFFER_WIDTH; g++) begin : g_slot
        assign slot[g] = data_async_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // A slot holds unread data while its synchronised write toggle differs from our read toggle.
    assign occupied      = sync_q[SYNC_STAGES-1] ^ rp_q;
    assign valid_o       = occupied[rd_idx] & ~isolate_i;
    assign pop           = valid_o & ready_i;
    assign data_o        = slot[rd_idx];
    assign readpointer_o = rp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            rp_q       <= '0;
            rd_idx     <= '0;
            fill_o     <= '0;
            isolated_o <= 1'b0;
        end else begin
            sync_q[0] <= writetoken_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            // Only one bit of rp_q flips per pop, keeping it safe for the writer's synchroniser.
            rp_q       <= rp_q ^ (pop ? BUFFER_WIDTH'(1) << rd_idx : '0);
            rd_idx     <= pop ? (rd_idx == IW'(BUFFER_WIDTH - 1) ? '0 : rd_idx + 1'b1) : rd_idx;
            fill_o     <= FW'($countones(occupied));
            isolated_o <= isolate_i;
        end
    end
endmodule

// File: tb/tb_axi_slice_dc_chan_reader.sv
// tb_axi_slice_dc_chan_reader: randomized and directed checks against a queue-based channel model
module tb_axi_slice_dc_chan_reader;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         isolate_i;
    logic         isolated_o;
    logic [511:0] data_async_i;
    logic [7:0]   writetoken_i;
    logic [7:0]   readpointer_o;
    logic [63:0]  data_o;
    logic         valid_o;
    logic         ready_i;
    logic [3:0]   fill_o;

    axi_slice_dc_chan_reader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .isolate_i(isolate_i), .isolated_o(isolated_o),
        .data_async_i(data_async_i), .writetoken_i(writetoken_i), .readpointer_o(readpointer_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .fill_o(fill_o)
    );

    always #5 clk_i = ~clk_i;

    logic [63:0] q_data[$];
    int          q_vis[$];
    int          n = 0;
    int          pops = 0;
    int          wr_cnt = 0;
    logic [7:0]  exp_rp = '0;
    logic [3:0]  exp_fill = '0;
    logic        exp_iso = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs (and optionally a writer push), check outputs mid-cycle, then advance the model over the edge.
    task automatic step(input bit iso, input bit rdy, input bit wr, input logic [63:0] d);
        int  s;
        int  cnt;
        bit  ev;
        isolate_i = iso;
        ready_i   = rdy;
        if (wr && q_data.size() < 8) begin
            s = wr_cnt % 8;
            data_async_i[s*64 +: 64] = d;
            writetoken_i[s] = ~writetoken_i[s];
            q_data.push_back(d);
            q_vis.push_back(n + 2);
            wr_cnt++;
        end
        @(negedge clk_i);
        ev = q_data.size() > 0 && q_vis[0] <= n && !iso;
        chk("valid", {63'd0, valid_o}, {63'd0, ev});
        if (ev) chk("data", data_o, q_data[0]);
        chk("readpointer", {56'd0, readpointer_o}, {56'd0, exp_rp});
        chk("fill", {60'd0, fill_o}, {60'd0, exp_fill});
        chk("isolated", {63'd0, isolated_o}, {63'd0, exp_iso});
        @(posedge clk_i);
        cnt = 0;
        foreach (q_vis[i]) if (q_vis[i] <= n) cnt++;
        exp_fill = 4'(cnt);
        exp_iso  = iso;
        if (ev && rdy) begin
            exp_rp[pops % 8] = ~exp_rp[pops % 8];
            pops++;
            void'(q_data.pop_front());
            void'(q_vis.pop_front());
        end
        n++;
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        isolate_i    = 1'b0;
        ready_i      = 1'b0;
        writetoken_i = '0;
        data_async_i = '0;
        #12;
        chk("reset_rp", {56'd0, readpointer_o}, 64'd0);
        chk("reset_valid", {63'd0, valid_o}, 64'd0);
        chk("reset_fill", {60'd0, fill_o}, 64'd0);
        chk("reset_isolated", {63'd0, isolated_o}, 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // full buffer, two laps across the wrap point
        for (int i = 0; i < 8; i++) step(0, 0, 1, 64'(i));
        for (int i = 0; i < 12; i++) step(0, 1, 0, '0);
        chk("lap1_rp", {56'd0, readpointer_o}, 64'hFF);
        for (int i = 8; i < 16; i++) step(0, 0, 1, 64'(i));
        for (int i = 0; i < 12; i++) step(0, 1, 0, '0);
        chk("lap2_rp", {56'd0, readpointer_o}, 64'h00);

        // single entry
        step(0, 0, 1, 64'hDEADBEEF_00000001);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        chk("single_rp", {56'd0, readpointer_o}, 64'h01);

        // backpressure
        for (int i = 0; i < 3; i++) step(0, 0, 1, 64'hB000 + 64'(i));
        for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);

        // isolation mid-stream
        for (int i = 0; i < 4; i++) step(0, 0, 1, 64'hC000 + 64'(i));
        step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

        // write arriving while earlier slots drain
        step(0, 0, 1, 64'hD000);
        step(0, 0, 1, 64'hD001);
        step(0, 0, 0, '0);
        step(0, 1, 1, 64'hD002);
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
        for (int i = 0; i < 20; i++) step(0, 1, 0, '0);

        // reset mid-operation: 5 entries, 2 popped, isolation active
        for (int i = 0; i < 5; i++) step(0, 0, 1, 64'hE000 + 64'(i));
        step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        step(1, 0, 0, '0);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_rp", {56'd0, readpointer_o}, 64'd0);
        chk("midrst_valid", {63'd0, valid_o}, 64'd0);
        chk("midrst_fill", {60'd0, fill_o}, 64'd0);
        chk("midrst_isolated", {63'd0, isolated_o}, 64'd0);
        writetoken_i = '0;
        q_data.delete();
        q_vis.delete();
        pops     = 0;
        wr_cnt   = 0;
        exp_rp   = '0;
        exp_fill = '0;
        exp_iso  = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(0, 0, 1, 64'hF00D);
        step(0, 0, 1, 64'hF00E);
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
        chk("post_rst_rp", {56'd0, readpointer_o}, 64'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slice_dc_chan_reader.md
# axi_slice_dc_chan_reader

Read-side endpoint of one channel of the dual-clock AXI slice. It receives the token-and-buffer async bundle produced by the opposite-domain writer, synchronises the write tokens into `clk_i`, and presents entries in order as a valid/ready stream. It returns the read pointer to the writer. One instance sits in the master-side slice per channel (AW, AR, W, R, B) and pairs with the writer half embedded in the slave-side slice.

## Interface
Parameters:
- DATA_WIDTH, 64: payload width of one slot (packed channel fields).
- BUFFER_WIDTH, 8: number of slots; ≥2.
- SYNC_STAGES, 2: synchroniser flops on `writetoken_i`; ≥2.

Ports:
- clk_i  in  1  reader-domain clock; single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- isolate_i  in  1  freeze output: no valid presented, no slot consumed.
- isolated_o  out  1  isolate_i registered; acknowledges isolation is in effect.
- data_async_i  in  BUFFER_WIDTH*DATA_WIDTH  writer's slot storage; slot i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- writetoken_i  in  BUFFER_WIDTH  async; bit i toggles once per write to slot i.
- readpointer_o  out  BUFFER_WIDTH  registered; bit i toggles once per read of slot i.
- data_o  out  DATA_WIDTH  payload of current head slot.
- valid_o  out  1  head slot holds unread data.
- ready_i  in  1  consumer accepts data_o.
- fill_o  out  $clog2(BUFFER_WIDTH+1)  registered count of occupied slots, as seen after synchronisation.

## Operation
- Slot i is occupied when `wt_sync[i] != rp_q[i]`. Here `wt_sync` is the last synchroniser stage and `rp_q` drives `readpointer_o`.
- The writer guarantees slot data is stable before it toggles the matching token bit. It does not rewrite slot i until it sees `readpointer_o[i]` toggle.
- The head index `rd_idx` is a binary counter over 0..BUFFER_WIDTH-1 and wraps to 0 after BUFFER_WIDTH-1.
- `valid_o = occupied[rd_idx] & ~isolate_i`, combinational from registers and isolate_i.
- `data_o = data_async_i` slice at `rd_idx`. It is combinational, and is don't-care when valid_o=0.
- Pop: when valid_o & ready_i, on that edge `rp_q[rd_idx]` toggles and `rd_idx` advances.
  - At most one pop per cycle.
  - Slots are consumed strictly in order. A later occupied slot is never read ahead of an empty head.
- Isolation: while isolate_i=1, valid_o=0 and no pop occurs regardless of ready_i.
  - Synchronisation and fill_o continue to update.
  - Deasserting isolate_i resumes at the same rd_idx; no data is lost or duplicated.
- fill_o = popcount(wt_sync ^ rp_q), registered. It therefore reflects a pop one cycle later.
- No error detection. A writer overrun (toggling a slot that is still occupied) is a protocol violation with undefined result.

## Timing
- Reset (async assert, synchronous-to-clk_i deassert handled upstream):
  - all synchroniser flops, rp_q, rd_idx, fill_o and isolated_o = 0;
  - readpointer_o = 0, valid_o = 0.
  - The writer resets its tokens to 0, so tokens are equal after reset.
- Latency: a `writetoken_i[i]` toggle that is stable before clk_i edge k makes valid_o high after edge k+SYNC_STAGES-1 (2 edges for default). fill_o updates one edge later.
- Throughput: one pop per clock when slots are occupied and ready_i=1. Back-to-back across the wrap point is required.
- readpointer_o changes only on clk_i edges and one bit at a time, so it is safe for the writer's synchroniser.
- Under backpressure (valid_o=1, ready_i=0), data_o and valid_o hold stable.
- isolated_o follows isolate_i with one cycle delay.
- Reset mid-operation clears all state immediately. Both sides are reset together by system design.

## Test plan
- Single entry: write slot 0 with 0xDEADBEEF_00000001 and toggle writetoken_i[0] → valid_o rises 2 edges later with that data; pop with ready_i=1 → readpointer_o=0x01, valid_o=0 next cycle, fill_o 1→0.
- Full buffer: fill all 8 slots with values 0..7 and tokens 0xFF, ready_i=1 → 8 consecutive pops with data 0..7, rd_idx wraps to 0, readpointer_o=0xFF, fill_o reaches 0. A second lap with 8..15 returns readpointer_o=0x00.
- Backpressure: 3 entries, ready_i=0 for 10 cycles → valid_o=1 and data_o constant, readpointer_o unchanged, fill_o=3. Then ready_i=1 → 3 pops in 3 cycles.
- Isolation mid-stream: 4 entries, pop 2, assert isolate_i for 5 cycles with ready_i=1 → valid_o=0, no readpointer_o change, isolated_o=1 one cycle later. Deassert → remaining 2 entries delivered in order.
- Async write during pop: toggle writetoken_i[2] while slots 0–1 are draining → no gap beyond the synchroniser latency, order 0,1,2 preserved.
- Reset mid-operation: 5 entries with 2 popped, pulse rst_ni low between edges → all outputs 0 immediately with no clock, and rd_idx=0 after release.
